// File: rtl/syn_fifo.sv
// rtl/syn_fifo.sv - single-clock synchronous FIFO with registered read port
//
// Ports:
//   clk, rst           : clock and synchronous active-high reset
//   wr, wr_data        : write request and data (ignored while full)
//   rd                 : read request (ignored while empty)
//   rd_data            : registered read data, holds between reads
//   rd_data_vld        : rd_data is the word returned by the previous edge's read
//   cfg_almost_full    : almost_full asserted when occupancy >= this value
//   cfg_almost_empty   : almost_empty asserted when occupancy <= this value
//   full, empty        : occupancy == data_depth / occupancy == 0
//   almost_full/empty  : threshold flags, decoded from the count register
//   fifo_num           : current occupancy, 0..data_depth

module syn_fifo #(
  parameter int data_width  = 32,
  parameter int data_depth  = 32,
  parameter int depth_width = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic [data_width-1:0]  wr_data,
  input  logic                   rd,
  output logic [data_width-1:0]  rd_data,
  output logic                   rd_data_vld,
  input  logic [depth_width:0]   cfg_almost_full,
  input  logic [depth_width:0]   cfg_almost_empty,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [depth_width:0]   fifo_num
);

  localparam logic [depth_width-1:0] last_ptr  = depth_width'(data_depth - 1);
  localparam logic [depth_width:0]   depth_num = (depth_width + 1)'(data_depth);

  logic [data_width-1:0]  mem [data_depth];
  logic [depth_width-1:0] wr_ptr;
  logic [depth_width-1:0] rd_ptr;
  logic                   wr_en;
  logic                   rd_en;

  // Flags come only from the count register, so there is no path from
  // wr/rd to any output.
  assign full         = (fifo_num == depth_num);
  assign empty        = (fifo_num == '0);
  assign almost_full  = (fifo_num >= cfg_almost_full);
  assign almost_empty = (fifo_num <= cfg_almost_empty);

  assign wr_en = wr & ~full;
  assign rd_en = rd & ~empty;

  // Storage is not reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      // Explicit wrap so non-power-of-two depths work.
      wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      rd_data     <= '0;
      rd_data_vld <= 1'b0;
    end else begin
      rd_data_vld <= rd_en;
      if (rd_en) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= (rd_ptr == last_ptr) ? '0 : rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_num <= '0;
    end else if (wr_en && !rd_en) begin
      fifo_num <= fifo_num + 1'b1;
    end else if (rd_en && !wr_en) begin
      fifo_num <= fifo_num - 1'b1;
    end
  end

endmodule

// File: tb/tb_syn_fifo.sv
// tb/tb_syn_fifo.sv - self-checking bench for syn_fifo against a queue model

module tb_syn_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr;
  logic [DW-1:0] wr_data;
  logic          rd;
  logic [DW-1:0] rd_data;
  logic          rd_data_vld;
  logic [AW:0]   cfg_almost_full;
  logic [AW:0]   cfg_almost_empty;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   fifo_num;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a plain queue of stored words plus the expected read port.
  logic [DW-1:0] model_q[$];
  logic          exp_vld = 1'b0;
  logic [DW-1:0] exp_rd  = '0;
  int            total_writes = 0;

  syn_fifo #(
    .data_width (DW),
    .data_depth (DEPTH),
    .depth_width(AW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wr              (wr),
    .wr_data         (wr_data),
    .rd              (rd),
    .rd_data         (rd_data),
    .rd_data_vld     (rd_data_vld),
    .cfg_almost_full (cfg_almost_full),
    .cfg_almost_empty(cfg_almost_empty),
    .full            (full),
    .empty           (empty),
    .almost_full     (almost_full),
    .almost_empty    (almost_empty),
    .fifo_num        (fifo_num)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and update the model; outputs are sampled #1 later.
  task automatic tick();
    bit we;
    bit re;
    we = wr && (model_q.size() < DEPTH);
    re = rd && (model_q.size() > 0);
    @(posedge clk);
    #1;
    if (rst) begin
      model_q.delete();
      exp_vld = 1'b0;
      exp_rd  = '0;
    end else begin
      if (re) begin
        exp_rd  = model_q.pop_front();
        exp_vld = 1'b1;
      end else begin
        exp_vld = 1'b0;
      end
      if (we) begin
        model_q.push_back(wr_data);
        total_writes++;
      end
    end
  endtask

  task automatic test_reset();
    cfg_almost_full  = 6'h1B;
    cfg_almost_empty = 6'h04;
    wr = 1'b0; rd = 1'b0; wr_data = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_tests++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_almost_empty got=%b exp=1", almost_empty); end
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
    n_tests++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full got=%b exp=0", almost_full); end
    n_tests++; if (fifo_num !== 6'd0) begin n_fail++; $display("FAIL reset_fifo_num got=%0d exp=0", fifo_num); end
    n_tests++; if (rd_data_vld !== 1'b0) begin n_fail++; $display("FAIL reset_rd_data_vld got=%b exp=0", rd_data_vld); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      wr = 1'b1; wr_data = DW'(i);
      tick();
      n_tests++; if (fifo_num !== 6'(i + 1)) begin n_fail++; $display("FAIL fill_num[%0d] got=%0d exp=%0d", i, fifo_num, i + 1); end
      n_tests++; if (almost_full !== (i + 1 >= 27)) begin n_fail++; $display("FAIL fill_almost_full[%0d] got=%b exp=%b", i, almost_full, (i + 1 >= 27)); end
      n_tests++; if (full !== (i + 1 == DEPTH)) begin n_fail++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i + 1 == DEPTH)); end
    end
    wr_data = 32'hDEAD;
    tick();
    wr = 1'b0;
    n_tests++; if (fifo_num !== 6'd32) begin n_fail++; $display("FAIL overflow_num got=%0d exp=32", fifo_num); end
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL overflow_full got=%b exp=1", full); end
  endtask

  task automatic test_drain_underflow();
    for (int i = 0; i <= DEPTH; i++) begin
      rd = 1'b1;
      tick();
      if (i < DEPTH) begin
        n_tests++; if (rd_data_vld !== 1'b1) begin n_fail++; $display("FAIL drain_vld[%0d] got=%b exp=1", i, rd_data_vld); end
        n_tests++; if (rd_data !== DW'(i)) begin n_fail++; $display("FAIL drain_data[%0d] got=%0h exp=%0h", i, rd_data, i); end
        n_tests++; if (fifo_num !== 6'(DEPTH - 1 - i)) begin n_fail++; $display("FAIL drain_num[%0d] got=%0d exp=%0d", i, fifo_num, DEPTH - 1 - i); end
        n_tests++; if (almost_empty !== (DEPTH - 1 - i <= 4)) begin n_fail++; $display("FAIL drain_almost_empty[%0d] got=%b exp=%b", i, almost_empty, (DEPTH - 1 - i <= 4)); end
      end else begin
        n_tests++; if (rd_data_vld !== 1'b0) begin n_fail++; $display("FAIL underflow_vld got=%b exp=0", rd_data_vld); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL underflow_empty got=%b exp=1", empty); end
      end
    end
    rd = 1'b0;
  endtask

  task automatic test_simultaneous();
    // Both requests while empty: only the write lands.
    wr = 1'b1; rd = 1'b1; wr_data = $urandom;
    tick();
    n_tests++; if (fifo_num !== 6'd1) begin n_fail++; $display("FAIL sim_empty_num got=%0d exp=1", fifo_num); end
    n_tests++; if (rd_data_vld !== 1'b0) begin n_fail++; $display("FAIL sim_empty_vld got=%b exp=0", rd_data_vld); end
    rd = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      wr_data = $urandom;
      tick();
    end
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL sim_prefull got=%b exp=1", full); end
    // Both requests while full: only the read lands.
    rd = 1'b1; wr_data = $urandom;
    tick();
    n_tests++; if (fifo_num !== 6'd31) begin n_fail++; $display("FAIL sim_full_num got=%0d exp=31", fifo_num); end
    n_tests++; if (rd_data_vld !== 1'b1) begin n_fail++; $display("FAIL sim_full_vld got=%b exp=1", rd_data_vld); end
    n_tests++; if (rd_data !== exp_rd) begin n_fail++; $display("FAIL sim_full_data got=%0h exp=%0h", rd_data, exp_rd); end
    wr = 1'b0;
    for (int i = 0; i < 21; i++) tick();
    n_tests++; if (fifo_num !== 6'd10) begin n_fail++; $display("FAIL sim_pre10_num got=%0d exp=10", fifo_num); end
    wr = 1'b1; wr_data = $urandom;
    tick();
    n_tests++; if (fifo_num !== 6'd10) begin n_fail++; $display("FAIL sim_mid_num got=%0d exp=10", fifo_num); end
    n_tests++; if (rd_data !== exp_rd || rd_data_vld !== 1'b1) begin n_fail++; $display("FAIL sim_mid_data got=%0h/%b exp=%0h/1", rd_data, rd_data_vld, exp_rd); end
    wr = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    rd = 1'b0;
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL sim_drained got=%b exp=1", empty); end
  endtask

  task automatic test_random();
    int wp;
    int rp;
    int start_writes;
    int errs;
    errs = 0;
    start_writes = total_writes;
    wp = 50; rp = 50;
    for (int c = 0; c < 10000; c++) begin
      if (c % 500 == 0) begin
        wp = $urandom_range(10, 90);
        rp = $urandom_range(10, 90);
      end
      wr      = ($urandom_range(0, 99) < wp) && !full;
      rd      = ($urandom_range(0, 99) < rp) && !empty;
      wr_data = DW'($urandom_range(0, 31));
      tick();
      if (c % 97 == 0) begin
        cfg_almost_full  = 6'($urandom_range(0, DEPTH));
        cfg_almost_empty = 6'($urandom_range(0, DEPTH));
        #1;
      end
      if (rd_data_vld !== exp_vld || (exp_vld && rd_data !== exp_rd)) begin
        if (errs < 10) $display("FAIL rand_read[%0d] got=%0h/%b exp=%0h/%b", c, rd_data, rd_data_vld, exp_rd, exp_vld);
        errs++;
      end
      if (fifo_num !== 6'(model_q.size()) || full !== (model_q.size() == DEPTH) || empty !== (model_q.size() == 0)) begin
        if (errs < 10) $display("FAIL rand_count[%0d] got=%0d exp=%0d", c, fifo_num, model_q.size());
        errs++;
      end
      if (almost_full !== (model_q.size() >= int'(cfg_almost_full)) ||
          almost_empty !== (model_q.size() <= int'(cfg_almost_empty))) begin
        if (errs < 10) $display("FAIL rand_flags[%0d] got=%b%b num=%0d", c, almost_full, almost_empty, model_q.size());
        errs++;
      end
    end
    wr = 1'b0; rd = 1'b0;
    n_tests++; if (errs != 0) begin n_fail++; $display("FAIL random_traffic got=%0d errors exp=0", errs); end
    n_tests++; if (total_writes - start_writes < 3 * DEPTH) begin n_fail++; $display("FAIL random_wraps got=%0d writes exp>=%0d", total_writes - start_writes, 3 * DEPTH); end
    cfg_almost_full  = 6'h1B;
    cfg_almost_empty = 6'h04;
  endtask

  task automatic test_reset_midstream();
    logic [DW-1:0] word;
    rst = 1'b1; tick(); rst = 1'b0;
    wr = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wr_data = $urandom;
      tick();
    end
    wr = 1'b0;
    n_tests++; if (fifo_num !== 6'd12) begin n_fail++; $display("FAIL mid_pre_num got=%0d exp=12", fifo_num); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_tests++; if (fifo_num !== 6'd0) begin n_fail++; $display("FAIL mid_rst_num got=%0d exp=0", fifo_num); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mid_rst_empty got=%b exp=1", empty); end
    word = 32'hA5C3_0F1E;
    wr = 1'b1; wr_data = word; tick(); wr = 1'b0;
    rd = 1'b1; tick(); rd = 1'b0;
    n_tests++; if (rd_data !== word || rd_data_vld !== 1'b1) begin n_fail++; $display("FAIL mid_new_word got=%0h/%b exp=%0h/1", rd_data, rd_data_vld, word); end
    tick();
    n_tests++; if (rd_data_vld !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL mid_after got=%b/%b exp=0/1", rd_data_vld, empty); end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_simultaneous();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
